uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver: receiving end of the 9600-baud serial link clocked from clk_100.
//  Synchronises the asynchronous rx pin and times bits with an internal counter
//  (no derived clock). Samples each bit at mid-period, presents the byte to the
//  processor side with a valid/ack handshake, and flags framing and overrun errors.
// PARAMETERS
//  CLKS_PER_BIT  10416  clk_100 cycles per bit (100 MHz / 9600); must be even, >= 8
//  DATA_BITS     8      data bits per frame, sent LSB first (fixed at 8 in this revision)
// PORTS
//  clk_100       in   1  system clock, 100 MHz; the only clock
//  rst_n         in   1  synchronous, active-low reset
//  rx            in   1  serial line, asynchronous, idles high
//  rx_data       out  8  last good received byte
//  rx_valid      out  1  rx_data holds an unconsumed byte
//  rx_ack        in   1  consumer takes rx_data; clears rx_valid
//  rx_overrun    out  1  1-cycle pulse: good byte completed while rx_valid=1 and no ack
//  rx_frame_err  out  1  1-cycle pulse: stop bit sampled low
//  rx_busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk_100 edge): state=IDLE, counters=0, sync flops=1,
//    rx_data=0, rx_valid=0, rx_overrun=0, rx_frame_err=0, rx_busy=0. Reset wins over
//    everything; a frame cut by reset is discarded.
//  - rx passes through 2 flops (rx_s); the FSM sees only rx_s.
//  - HALF = CLKS_PER_BIT/2. bit_cnt counts 0..CLKS_PER_BIT-1; clears on state change.
//  - FSM states:
//    IDLE:  rx_s==0 -> START (cnt=0).
//    START: at cnt==HALF-1, rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch rejected, no flag).
//    DATA:  at cnt==CLKS_PER_BIT-1, shift rx_s into shift reg MSB (right shift),
//           idx++. After bit 7 -> STOP.
//    STOP:  at cnt==CLKS_PER_BIT-1 (mid stop bit): rx_s==1 -> good byte, IDLE;
//           rx_s==0 -> pulse rx_frame_err, byte dropped, -> BREAK.
//    BREAK: wait until rx_s==1 -> IDLE (held-low line never re-triggers).
//  - IDLE is re-entered at mid stop bit, so a following start edge is never missed.
//  - Latency: if START is entered at cycle t0, rx_valid/rx_data update at the
//    edge t0 + HALF + 9*CLKS_PER_BIT.
//  - Handshake, evaluated on the good-byte cycle G:
//    rx_valid=0              -> rx_data<=byte, rx_valid<=1.
//    rx_valid=1, rx_ack=1    -> rx_data<=byte, rx_valid stays 1 (no overrun).
//    rx_valid=1, rx_ack=0    -> new byte dropped, rx_data unchanged, rx_overrun pulse.
//    No byte completing: rx_ack=1 clears rx_valid next edge; rx_ack while rx_valid=0
//    is ignored.
//  - rx_busy is combinational from state (!=IDLE); all other outputs are registered.
// STRUCTURE
//  - uart_defs.vh (shared include, also used by the future uart_tx): state encodings
//    (IDLE/START/DATA/STOP/BREAK, 3 bits), DATA_BITS, default CLKS_PER_BIT for 9600 baud.
//  - One sub-module: uart_bit_timer (bit_cnt with clear, HALF and FULL strobes),
//    shared with uart_tx. Synchroniser, FSM, shift register and handshake sit in uart_rx.
// TESTING  (CLKS_PER_BIT=16 for all sims; bench drives rx at 16 clk/bit)
//  1. Frame 0xA5 with stop=1 -> rx_valid rises at t0+8+144, rx_data=0xA5, stays
//     high until rx_ack, rx_frame_err=0.
//  2. rx low for 4 cycles then high -> START aborts, no rx_valid/err, rx_busy back
//     to 0 within 10 cycles.
//  3. Frame 0x3C with stop=0, line held low 40 cycles -> rx_frame_err one pulse,
//     rx_valid=0, no new START until rx high, then 0x3C frame received OK.
//  4. 0x11 then 0x22 back-to-back, no ack -> rx_data=0x11, one rx_overrun pulse;
//     ack, then 0x33 -> rx_data=0x33.
//  5. rx_ack on exactly cycle G of byte 0x77 with 0x11 pending -> rx_valid stays 1,
//     rx_data=0x77, no rx_overrun.
//  6. rst_n low 2 cycles during DATA bit 4 -> all outputs at reset values; next
//     0x5A frame received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame constants and receiver state encoding.
package uart_rx_pkg;

    localparam int unsigned UART_DATA_BITS         = 8;
    localparam int unsigned UART_CLKS_PER_BIT_9600 = 10416;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with synchronous clear; strobes at mid-bit and at end of bit period.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic half_o,
    output logic full_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        half_o = (cnt_q == HalfLast);
        full_o = (cnt_q == FullLast);
        if (clear_i || full_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ack handshake, framing and overrun flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_9600,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam logic [2:0] LastIdx = 3'(DATA_BITS - 1);

    state_e     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       good_byte;
    logic       timer_clear, bit_half, bit_full;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i  (clk_100),
        .rst_ni (rst_n),
        .clear_i(timer_clear),
        .half_o (bit_half),
        .full_o (bit_full)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        frame_err_d = 1'b0;
        good_byte   = 1'b0;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (bit_half) state_d = rx_s_q ? StIdle : StData;
            end
            StData: begin
                if (bit_full) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LastIdx) state_d = StStop;
                end
            end
            StStop: begin
                // Leaving at mid stop bit keeps a following start edge from being missed.
                if (bit_full) begin
                    if (rx_s_q) begin
                        good_byte = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (good_byte) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack) begin
            valid_d = 1'b0;
        end
    end

    assign timer_clear = (state_q == StIdle) || (state_d != state_q);

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= StIdle;
            shift_q     <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = overrun_q;
    assign rx_frame_err = frame_err_q;
    assign rx_busy      = (state_q != StIdle);

endmodule
